// File: rtl/spi_cmd_pkg.sv
// -----------------------------------------------------------------------------
// spi_cmd_pkg
// Definitions shared by the SPI command path (receiver and responder):
//   - receiver FSM state encoding
//   - word geometry (bytes per word) and header word-count limits
//   - byte-lane order: little-endian, lane 0 travels first and carries bits 7:0
//   - put_lane(): places one byte into its lane of a 32-bit word
// -----------------------------------------------------------------------------
package spi_cmd_pkg;

    // Receiver control states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2
    } rx_state_e;

    // Bytes per memory word
    localparam int WORD_BYTES = 4;

    // Header word-count limits; a header outside this range is not a frame
    localparam int HDR_MIN_WORDS = 1;
    localparam int HDR_MAX_WORDS = 255;

    // Byte-lane order on the wire. 1'b1: first byte lands in bits 7:0.
    // The responder serialises with the same constant so both ends agree.
    localparam logic LANE_ORDER_LE = 1'b1;

    // Return 'word' with byte position 'lane' (in wire order) replaced by 'byte_in'
    function automatic logic [31:0] put_lane(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [7:0]  byte_in);
        logic [31:0] res;
        logic [1:0]  pos;
        res = word;
        pos = LANE_ORDER_LE ? lane : (2'd3 - lane);
        res[{pos, 3'b000} +: 8] = byte_in;
        return res;
    endfunction

endpackage

// File: rtl/cmd_receiver_if.sv
// -----------------------------------------------------------------------------
// cmd_receiver_if
// Bundles the byte stream from the SPI byte receiver, the destination region,
// the memory write handshake and the status outputs of cmd_receiver.
//   slave  : the cmd_receiver side (consumes bytes, drives memory requests)
//   master : the environment side (byte source, memory, command logic)
// Signals:
//   byte_valid/byte_recv      one-cycle byte strobe and data
//   region_begin/region_end   destination window, [begin, end) in words
//   mem_avail/mem_done        memory may accept / current write committed
//   mem_w_en/mem_addr/mem_wdata  write request, held until mem_done
//   cmd_ready                 one-cycle pulse: frame fully in memory
//   busy, err_overrun, err_region  status
// -----------------------------------------------------------------------------
interface cmd_receiver_if #(
    parameter int ADDR_W = 16
);
    logic              byte_valid;
    logic [7:0]        byte_recv;
    logic [ADDR_W-1:0] region_begin;
    logic [ADDR_W-1:0] region_end;
    logic              mem_avail;
    logic              mem_done;
    logic              mem_w_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cmd_ready;
    logic              busy;
    logic              err_overrun;
    logic              err_region;

    modport slave (
        input  byte_valid, byte_recv, region_begin, region_end, mem_avail, mem_done,
        output mem_w_en, mem_addr, mem_wdata, cmd_ready, busy, err_overrun, err_region
    );

    modport master (
        output byte_valid, byte_recv, region_begin, region_end, mem_avail, mem_done,
        input  mem_w_en, mem_addr, mem_wdata, cmd_ready, busy, err_overrun, err_region
    );

endinterface

// File: rtl/cmd_receiver_word_packer.sv
// -----------------------------------------------------------------------------
// word_packer
// Assembles four bytes into a 32-bit word (lane order from spi_cmd_pkg) and
// moves each completed word into a hold register. Assembly and hold form a
// double buffer: the next word collects while the held word is being written.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   clear          flush byte index and hold-valid (receiver not in a frame)
//   byte_en        accept byte_in into the current lane
//   byte_in        incoming byte
//   release_word   the held word has been committed to memory this cycle
//   hold_data      held word
//   hold_full      hold register holds an unwritten word
//   word_done      this cycle's byte completes a word (combinational)
//   overrun        word completes while hold is occupied and not being released
// -----------------------------------------------------------------------------
module word_packer
    import spi_cmd_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    input  logic        release_word,
    output logic [31:0] hold_data,
    output logic        hold_full,
    output logic        word_done,
    output logic        overrun
);

    localparam logic [1:0] LAST_LANE = 2'(WORD_BYTES - 1);

    logic [1:0]  idx_r;
    logic [31:0] asm_r;
    logic [31:0] hold_r;
    logic        hold_full_r;

    // Word completion and overrun detection for the current byte
    always_comb begin
        word_done = byte_en && (idx_r == LAST_LANE);
        // A release in the same cycle frees the hold slot in time for the new word
        overrun   = word_done && hold_full_r && !release_word;
    end

    // Byte assembly, hold register load and hold-valid tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r       <= 2'd0;
            asm_r       <= 32'd0;
            hold_r      <= 32'd0;
            hold_full_r <= 1'b0;
        end else if (clear) begin
            idx_r       <= 2'd0;
            asm_r       <= 32'd0;
            hold_full_r <= 1'b0;
        end else begin
            if (byte_en) begin
                asm_r <= put_lane(asm_r, idx_r, byte_in);
                idx_r <= idx_r + 2'd1;
            end
            if (word_done) begin
                // The fourth byte goes straight into hold together with the assembled three
                hold_r      <= put_lane(asm_r, idx_r, byte_in);
                hold_full_r <= 1'b1;
            end else if (release_word) begin
                hold_full_r <= 1'b0;
            end
        end
    end

    assign hold_data = hold_r;
    assign hold_full = hold_full_r;

endmodule

// File: rtl/cmd_receiver.sv
// -----------------------------------------------------------------------------
// cmd_receiver
// Frames bytes from the SPI byte receiver into commands (one header byte with
// the word count N, then N little-endian 32-bit words) and writes the words to
// consecutive addresses of a memory region. After the last word is committed,
// cmd_ready pulses for one cycle.
// Ports:
//   clk   system clock
//   rst   synchronous, active-high reset
//   bus   cmd_receiver_if.slave: byte stream, region, memory handshake, status
// Parameters:
//   ADDR_W     memory word-address width (must match the interface)
//   MAX_WORDS  largest accepted header count (<= 255)
// -----------------------------------------------------------------------------
module cmd_receiver
    import spi_cmd_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int MAX_WORDS = 255
)(
    input  logic          clk,
    input  logic          rst,
    cmd_receiver_if.slave bus
);

    localparam logic [7:0] MAX_HDR = 8'(MAX_WORDS);
    localparam logic [7:0] MIN_HDR = 8'(HDR_MIN_WORDS);

    rx_state_e         state_r;
    logic [7:0]        words_left_r;
    logic [ADDR_W-1:0] ptr_r;
    logic              mem_w_en_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [31:0]       mem_wdata_r;
    logic              cmd_ready_r;
    logic              busy_r;
    logic              err_overrun_r;
    logic              err_region_r;

    logic              collect_byte_s;
    logic              pack_clear_s;
    logic              release_s;
    logic              hdr_ok_s;
    logic              region_fits_s;
    logic              hdr_accept_s;
    logic              engine_run_s;
    logic [ADDR_W:0]   region_need_s;
    logic [31:0]       hold_data_s;
    logic              hold_full_s;
    logic              word_done_s;
    logic              overrun_s;

    // Header qualification, region check and handshake qualifiers
    always_comb begin
        collect_byte_s = bus.byte_valid && (state_r == ST_COLLECT);
        pack_clear_s   = (state_r == ST_IDLE);
        release_s      = mem_w_en_r && bus.mem_done;
        hdr_ok_s       = (bus.byte_recv >= MIN_HDR) && (bus.byte_recv <= MAX_HDR);
        // One extra bit so a region near the top of the address space cannot wrap
        region_need_s  = {1'b0, bus.region_begin} + {{(ADDR_W - 7){1'b0}}, bus.byte_recv};
        region_fits_s  = (region_need_s <= {1'b0, bus.region_end});
        hdr_accept_s   = (state_r == ST_IDLE) && bus.byte_valid && hdr_ok_s && region_fits_s;
        // Writes only run inside a live frame; an overrun kills the pending request
        engine_run_s   = ((state_r == ST_COLLECT) && !overrun_s) || (state_r == ST_DRAIN);
    end

    word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear        (pack_clear_s),
        .byte_en      (collect_byte_s),
        .byte_in      (bus.byte_recv),
        .release_word (release_s),
        .hold_data    (hold_data_s),
        .hold_full    (hold_full_s),
        .word_done    (word_done_s),
        .overrun      (overrun_s)
    );

    // Frame control FSM: header accept, word counting, drain and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            words_left_r  <= 8'd0;
            cmd_ready_r   <= 1'b0;
            busy_r        <= 1'b0;
            err_overrun_r <= 1'b0;
            err_region_r  <= 1'b0;
        end else begin
            cmd_ready_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.byte_valid && hdr_ok_s) begin
                        err_overrun_r <= 1'b0;
                        if (region_fits_s) begin
                            words_left_r <= bus.byte_recv;
                            err_region_r <= 1'b0;
                            busy_r       <= 1'b1;
                            state_r      <= ST_COLLECT;
                        end else begin
                            // Frame does not fit: flag it and treat following bytes as headers
                            err_region_r <= 1'b1;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (overrun_s) begin
                        err_overrun_r <= 1'b1;
                        busy_r        <= 1'b0;
                        state_r       <= ST_IDLE;
                    end else if (word_done_s) begin
                        words_left_r <= words_left_r - 8'd1;
                        if (words_left_r == 8'd1) begin
                            state_r <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Only the final word can be in flight here
                    if (release_s) begin
                        cmd_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Write engine: issue the held word, hold the request until mem_done
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_w_en_r  <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= 32'd0;
            ptr_r       <= '0;
        end else if (hdr_accept_s) begin
            ptr_r <= bus.region_begin;
        end else if (!engine_run_s) begin
            mem_w_en_r <= 1'b0;
        end else if (release_s) begin
            // Dropping for one cycle guarantees a gap between requests
            mem_w_en_r <= 1'b0;
            ptr_r      <= ptr_r + 1'b1;
        end else if (!mem_w_en_r && hold_full_s && bus.mem_avail) begin
            mem_w_en_r  <= 1'b1;
            mem_addr_r  <= ptr_r;
            mem_wdata_r <= hold_data_s;
        end else begin
            mem_w_en_r <= mem_w_en_r;
        end
    end

    assign bus.mem_w_en    = mem_w_en_r;
    assign bus.mem_addr    = mem_addr_r;
    assign bus.mem_wdata   = mem_wdata_r;
    assign bus.cmd_ready   = cmd_ready_r;
    assign bus.busy        = busy_r;
    assign bus.err_overrun = err_overrun_r;
    assign bus.err_region  = err_region_r;

endmodule
